// File: rtl/mac_tx_arbiter_if.sv
// mac_tx_arbiter_if: bundle of the endpoint-FIFO side and MAC side signals
// seen by mac_tx_arbiter, plus the grant status outputs.
//
// Handshake semantics: mac_data_ready is a level kick. Once raised it stays
// high until the MAC reports a non-IDLE mac_tr_state, and it is then dropped
// on the following clock. mac_rd_en is a per-cycle read strobe. A byte moves
// in every cycle that mac_rd_en is high while mac_fifo_empty is low.
// mac_rd_start marks the first read of a frame. Both strobes reach only the
// granted source. src_ready is a level request that may drop at any time
// without disturbing a grant already given.
//
// Modports: master is the arbiter, slave is the environment.
interface mac_tx_arbiter_if #(
  parameter int NUM_SRC = 2
);
  localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]   src_ready;
  logic [NUM_SRC*8-1:0] src_rd_data;
  logic [NUM_SRC-1:0]   src_empty;
  logic [NUM_SRC-1:0]   src_rd_en;
  logic [NUM_SRC-1:0]   src_rd_start;
  logic [2:0]           mac_tr_state;
  logic                 mac_rd_en;
  logic                 mac_rd_start;
  logic                 mac_data_ready;
  logic [7:0]           mac_rd_data;
  logic                 mac_fifo_empty;
  logic                 grant_valid;
  logic [GW-1:0]        grant_id;
  logic                 frame_done;
  logic                 start_err;

  modport master (
    input  src_ready, src_rd_data, src_empty, mac_tr_state, mac_rd_en, mac_rd_start,
    output src_rd_en, src_rd_start, mac_data_ready, mac_rd_data, mac_fifo_empty,
           grant_valid, grant_id, frame_done, start_err
  );

  modport slave (
    output src_ready, src_rd_data, src_empty, mac_tr_state, mac_rd_en, mac_rd_start,
    input  src_rd_en, src_rd_start, mac_data_ready, mac_rd_data, mac_fifo_empty,
           grant_valid, grant_id, frame_done, start_err
  );
endinterface

// File: rtl/mac_tx_arbiter.sv
// mac_tx_arbiter: frame-level scheduler that shares one MAC transmitter
// between NUM_SRC endpoint byte FIFOs. A ready source is granted and the MAC
// is kicked. The MAC read handshake is then steered to that source until the
// MAC returns to IDLE after the inter-frame gap.
//
// Optional build macro MAC_TX_ARB_PRIO0_EN gives source 0 strict priority.
// The other sources stay round-robin. Without the macro, arbitration is pure
// round-robin across all sources.
//
// state_o exposes the FSM state: 0 IDLE, 1 START, 2 BUSY, 3 GAP, 4 DONE.
module mac_tx_arbiter #(
  parameter int NUM_SRC       = 2,
  parameter int START_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  mac_tx_arbiter_if.master bus,
  output logic [2:0]       state_o
);

  localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = $clog2(START_TIMEOUT + 1);

  localparam logic [2:0] MAC_IDLE = 3'd0;
  localparam logic [2:0] MAC_IFG  = 3'd6;

  typedef enum logic [2:0] {
    A_IDLE  = 3'd0,
    A_START = 3'd1,
    A_BUSY  = 3'd2,
    A_GAP   = 3'd3,
    A_DONE  = 3'd4
  } arb_state_e;

  arb_state_e    state_q, state_d;
  logic [GW-1:0] grant_id_q, grant_id_d;
  logic [GW-1:0] last_grant_q, last_grant_d;
  logic          grant_valid_q, grant_valid_d;
  logic          data_ready_q, data_ready_d;
  logic          start_err_q, start_err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [GW-1:0] rr_winner;
  logic          rr_found;
  logic          prio_hit;
  logic [GW-1:0] winner;
  logic          any_ready;

  assign any_ready = |bus.src_ready;

  // Round-robin search: first ready source at or after last_grant+1, wrapping.
  always_comb begin
    rr_winner = '0;
    rr_found  = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        if (!rr_found && (j == ((int'(last_grant_q) + k) % NUM_SRC)) && bus.src_ready[j]) begin
          rr_found  = 1'b1;
          rr_winner = GW'(j);
        end
      end
    end
  end

`ifdef MAC_TX_ARB_PRIO0_EN
  // Source 0 overrides the round-robin choice whenever it is ready.
  assign prio_hit = bus.src_ready[0];
`else
  // Pure round-robin: no source is privileged.
  assign prio_hit = 1'b0;
`endif

  assign winner = prio_hit ? '0 : rr_winner;

  // Next-state logic: grant, kick, frame tracking and kick timeout.
  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    last_grant_d  = last_grant_q;
    grant_valid_d = grant_valid_q;
    data_ready_d  = data_ready_q;
    start_err_d   = 1'b0;
    cnt_d         = cnt_q;
    case (state_q)
      A_IDLE: begin
        if (any_ready) begin
          grant_id_d    = winner;
          grant_valid_d = 1'b1;
          data_ready_d  = 1'b1;
          cnt_d         = '0;
          state_d       = A_START;
        end
      end
      A_START: begin
        if (bus.mac_tr_state != MAC_IDLE) begin
          data_ready_d = 1'b0;
          state_d      = A_BUSY;
        end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
          // The MAC never answered the kick. Release the grant without
          // advancing the round-robin pointer so the same source retries.
          data_ready_d  = 1'b0;
          grant_valid_d = 1'b0;
          start_err_d   = 1'b1;
          state_d       = A_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      A_BUSY: begin
        // Only IFG ends the frame. A transient IDLE here is ignored.
        if (bus.mac_tr_state == MAC_IFG) begin
          state_d = A_GAP;
        end
      end
      A_GAP: begin
        if (bus.mac_tr_state == MAC_IDLE) begin
          state_d = A_DONE;
        end
      end
      A_DONE: begin
        last_grant_d  = grant_id_q;
        grant_valid_d = 1'b0;
        state_d       = A_IDLE;
      end
      default: begin
        state_d       = A_IDLE;
        grant_valid_d = 1'b0;
        data_ready_d  = 1'b0;
      end
    endcase
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= A_IDLE;
      grant_id_q    <= '0;
      last_grant_q  <= GW'(NUM_SRC - 1);
      grant_valid_q <= 1'b0;
      data_ready_q  <= 1'b0;
      start_err_q   <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      last_grant_q  <= last_grant_d;
      grant_valid_q <= grant_valid_d;
      data_ready_q  <= data_ready_d;
      start_err_q   <= start_err_d;
      cnt_q         <= cnt_d;
    end
  end

  // Steer data/empty to the MAC and the read strobes to the granted source.
  always_comb begin
    bus.mac_rd_data    = 8'h00;
    bus.mac_fifo_empty = 1'b1;
    bus.src_rd_en      = '0;
    bus.src_rd_start   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_valid_q && (grant_id_q == GW'(i))) begin
        bus.mac_rd_data     = bus.src_rd_data[8*i +: 8];
        bus.mac_fifo_empty  = bus.src_empty[i];
        bus.src_rd_en[i]    = bus.mac_rd_en;
        bus.src_rd_start[i] = bus.mac_rd_start;
      end
    end
  end

  assign bus.mac_data_ready = data_ready_q;
  assign bus.grant_valid    = grant_valid_q;
  assign bus.grant_id       = grant_id_q;
  assign bus.frame_done     = (state_q == A_DONE);
  assign bus.start_err      = start_err_q;
  assign state_o            = state_q;

endmodule
